imem_loader_responder: RTL and testbench

Instruction-memory responder for the single-cycle core's fetch port. It serves `inst` for every `iAddr` the core presents. It also owns a boot-load sequence: after `reset` it holds the core in reset, accepts a program as a valid/ready word stream, and then releases the core. It sits between the external program source (testbench, UART bridge or ROM streamer) and the core's `iAddr`/`inst` pins, and drives the core's `reset`.

---
 rtl/imem_loader_responder.sv | 104 ++++++++++
 tb/tb_imem_loader_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_responder.sv
// Instruction-memory responder with boot loader: streams a program in, then releases the core.
// Optional macro IMEM_BOUNDS_CHECK_EN enables out-of-range fetch detection and the sticky fault flag.
module imem_loader_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iAddr,
  output logic [31:0] inst,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_reset,
  output logic        fault
);

  // state  | meaning
  // LOAD   | accepting program words, core held in reset
  // HOLD   | one settle cycle after the last write, core still in reset
  // RUN    | core released, fetches served from memory
  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [1:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   word_count_q, word_count_d;
  logic                  fault_q, fault_d;
  logic [31:0]           mem_q [DEPTH];

  logic                  xfer;
  logic                  wr_en;
  logic [31:0]           addr_off;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_hit;
  logic                  oob;

  assign load_ready = (state_q == S_LOAD);
  assign cpu_reset  = (state_q != S_RUN);
  assign xfer       = load_valid & load_ready;
  // Reset wins over a coincident transfer, so the memory write is gated too.
  assign wr_en      = xfer & ~reset;

  assign addr_off = iAddr - BASE_ADDR;
  assign rd_idx   = addr_off[DEPTH_LOG2+1:2];
  assign rd_hit   = ({1'b0, rd_idx} < word_count_q);

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic [32:0] SPAN = 33'(4) << DEPTH_LOG2;
  assign oob   = (iAddr < BASE_ADDR) | ({1'b0, addr_off} >= SPAN) | (iAddr[1:0] != 2'b00);
  assign fault = fault_q;
`else
  logic unused_addr_bits;
  assign oob              = 1'b0;
  assign fault            = 1'b0;
  assign unused_addr_bits = ^{addr_off[31:DEPTH_LOG2+2], addr_off[1:0], fault_q};
`endif

  assign inst = ((state_q == S_RUN) && rd_hit && !oob) ? mem_q[rd_idx] : 32'h0000_0000;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    fault_d      = fault_q;
    case (state_q)
      S_LOAD: begin
        if (xfer) begin
          wr_ptr_d     = wr_ptr_q + DEPTH_LOG2'(1);
          word_count_d = word_count_q + (DEPTH_LOG2 + 1)'(1);
          // A full memory ends the load even without load_last.
          if (load_last || (&wr_ptr_q)) state_d = S_HOLD;
        end
      end
      S_HOLD:  state_d = S_RUN;
      S_RUN:   fault_d = fault_q | oob;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      fault_q      <= fault_d;
    end
  end

  // Contents survive reset; word_count masks stale words.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= load_data;
  end

endmodule

// File: tb/tb_imem_loader_responder.sv
// Directed bench for imem_loader_responder: a default-depth instance and a 4-word instance.
// Fetch expectations come from a bench-side memory model and are queued before each compare.
module tb_imem_loader_responder;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iAddr, inst;
  logic        load_valid, load_last, load_ready, cpu_reset, fault;
  logic [31:0] load_data;

  logic [31:0] iAddr2, inst2;
  logic        load_valid2, load_last2, load_ready2, cpu_reset2, fault2;
  logic [31:0] load_data2;

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [1024];
  int          model_cnt = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;

  imem_loader_responder dut (
    .clk(clk), .reset(reset), .iAddr(iAddr), .inst(inst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .cpu_reset(cpu_reset), .fault(fault)
  );

  imem_loader_responder #(.DEPTH_LOG2(2)) dut2 (
    .clk(clk), .reset(reset), .iAddr(iAddr2), .inst(inst2),
    .load_valid(load_valid2), .load_data(load_data2), .load_last(load_last2),
    .load_ready(load_ready2), .cpu_reset(cpu_reset2), .fault(fault2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    logic [31:0] off;
    int          idx;
    off = a - BASE;
    idx = int'(off[11:2]);
`ifdef IMEM_BOUNDS_CHECK_EN
    if (a < BASE || off >= 32'd4096 || a[1:0] != 2'b00) return 32'h0;
`endif
    return (idx < model_cnt) ? model_mem[idx] : 32'h0;
  endfunction

  // Queue the model's answer, present the address, then compare what comes back.
  task automatic fetch(input string tag, input logic [31:0] a);
    logic [31:0] e;
    string       t;
    exp_q.push_back(model_fetch(a));
    tag_q.push_back(tag);
    iAddr = a;
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, inst, e);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    model_mem[model_cnt] = d;
    model_cnt++;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_cnt = 0;
  endtask

  logic [31:0] s2 [6];

  initial begin
    reset = 1'b1; iAddr = BASE; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    iAddr2 = BASE; load_valid2 = 1'b0; load_data2 = '0; load_last2 = 1'b0;
    tick(); tick();
    chk("rst_load_ready", {31'b0, load_ready}, 32'd1);
    chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("rst_inst", inst, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    reset = 1'b0;
    model_cnt = 0;

    // Three-word program, release timing.
    send(32'h2008_0005, 1'b0);
    send(32'h2009_0007, 1'b0);
    chk("load_inst_zero", inst, 32'h0);
    send(32'h0109_5020, 1'b1);
    chk("hold_ready_low", {31'b0, load_ready}, 32'd0);
    chk("hold_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("hold_inst_zero", inst, 32'h0);
    tick();
    chk("run_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    fetch("run_w2", 32'h0040_0008);
    fetch("run_w0", 32'h0040_0000);
    fetch("run_w1", 32'h0040_0004);
    fetch("run_beyond_count", 32'h0040_000C);

    // load_valid in RUN must not write.
    load_valid = 1'b1; load_data = 32'hFFFF_FFFF; load_last = 1'b1;
    tick(); tick();
    load_valid = 1'b0; load_last = 1'b0;
    fetch("run_ignore_valid_w3", 32'h0040_000C);
    fetch("run_ignore_valid_w0", 32'h0040_0000);

    // Out-of-range fetches.
    fetch("oob_1000", 32'h0040_1000);
    tick();
`ifdef IMEM_BOUNDS_CHECK_EN
    chk("fault_set", {31'b0, fault}, 32'd1);
    iAddr = BASE;
    tick();
    chk("fault_sticky", {31'b0, fault}, 32'd1);
`else
    chk("fault_tied0", {31'b0, fault}, 32'd0);
`endif
    fetch("misaligned", 32'h0040_0001);
    fetch("below_base", 32'h003F_FFFC);

    // Reset from RUN.
    do_reset();
    chk("rerun_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("rerun_ready", {31'b0, load_ready}, 32'd1);
    chk("rerun_fault", {31'b0, fault}, 32'd0);

    // Gapped stream: idle cycles must not advance the pointer.
    send(32'hAAAA_0001, 1'b0);
    tick();
    chk("gap_ready", {31'b0, load_ready}, 32'd1);
    send(32'hBBBB_0002, 1'b0);
    tick();
    send(32'hCCCC_0003, 1'b1);
    tick();
    fetch("gap_w0", 32'h0040_0000);
    fetch("gap_w1", 32'h0040_0004);
    fetch("gap_w2", 32'h0040_0008);
    fetch("gap_w3", 32'h0040_000C);

    // Partial load aborted by reset, then a one-word reload.
    do_reset();
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    do_reset();
    send(32'hDEAD_BEEF, 1'b1);
    tick();
    chk("reload_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    fetch("reload_w0", 32'h0040_0000);
    fetch("reload_w1_masked", 32'h0040_0004);

    // Small instance: memory-full terminates the load.
    for (int i = 0; i < 6; i++) s2[i] = 32'h5000_0000 + 32'(i * 17 + 3);
    for (int i = 0; i < 6; i++) begin
      load_valid2 = 1'b1;
      load_data2  = s2[i];
      tick();
      if (i < 3) chk($sformatf("full_ready_%0d", i), {31'b0, load_ready2}, 32'd1);
      if (i == 3) chk("full_hold_ready", {31'b0, load_ready2}, 32'd0);
      if (i == 3) chk("full_hold_cpu_reset", {31'b0, cpu_reset2}, 32'd1);
      if (i == 4) chk("full_run_cpu_reset", {31'b0, cpu_reset2}, 32'd0);
    end
    load_valid2 = 1'b0;
    iAddr2 = 32'h0040_000C; #1;
    chk("full_w3", inst2, s2[3]);
    iAddr2 = 32'h0040_0000; #1;
    chk("full_w0", inst2, s2[0]);
    iAddr2 = 32'h0040_0010; #1;
`ifdef IMEM_BOUNDS_CHECK_EN
    chk("full_wrap", inst2, 32'h0);
`else
    chk("full_wrap", inst2, s2[0]);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
